spi_reg_responder: RTL and testbench
====================================

# spi_reg_responder

SPI-mode-0/2 responder that exposes a bank of 8-bit configuration registers to an external SPI master over a fixed 16-bit command frame. Oversamples SCLK/MOSI/CE in the system clock domain, decodes a read/write command plus address, commits writes to the register bank and shifts read data back on MISO within the same frame. Sits beside `spi_slave` as its register-mapped counterpart. Fabric logic consumes register contents in parallel and is notified of every SPI write.

## Interface
- `p_num_regs`, 16: number of 8-bit registers; valid range 1..128.
- `p_cpol`, 0: SCLK idle level. CPHA fixed at 0.
- `p_timeout`, 1024: clk cycles without an SCLK edge mid-frame before abort. Used only when `SPI_RESP_TIMEOUT_EN` is defined.
- `clk` in 1: system clock.
- `resetn` in 1: reset. Synchronous and active-low.
- `i_sclk` in 1: SPI clock, asynchronous.
- `i_mosi` in 1: master out, slave in, asynchronous.
- `i_ce` in 1: chip enable, active-low, asynchronous.
- `o_miso` out 1: slave out, master in; registered.
- `op_regs` out 8*p_num_regs: register bank, reg n at bits [8n+7:8n].
- `o_wr_strobe` out 1: one-cycle pulse on each committed write.
- `op_wr_addr` out 7: address of last committed write.
- `o_frame_done` out 1: one-cycle pulse on each completed 16-bit frame, read or write.
- `o_error` out 1: one-cycle pulse on aborted frame or out-of-range address.

## Operation
- Frame format, MSB first:
  - bit15: R/nW (1 = read).
  - bits14:8: address.
  - bits7:0: write data for writes; don't-care on MOSI for reads.
- Synchronization and edge detection:
  - `i_sclk`, `i_mosi`, `i_ce` each pass through a 2-FF synchronizer.
  - Edges are detected on the synchronized SCLK.
  - Leading edge = transition away from `p_cpol`; trailing edge = transition back to it.
- MOSI is sampled on leading edges. MISO changes on trailing edges.
- State machine:
  - IDLE: CE high. Bit counter = 0, MISO = 0. CE falling goes to CMD.
  - CMD: shifts 8 bits (R/nW + address). On the 8th leading edge, latch command/address.
    - For a read, load the shift register with reg[addr], or 0x00 if addr ≥ `p_num_regs`.
    - On that bit's trailing edge, drive data bit7 on MISO.
    - Go to DATA.
  - DATA: shifts 8 bits. On the 16th leading edge:
    - Write with valid address: reg[addr] ← data, `o_wr_strobe` and `o_frame_done` pulse, `op_wr_addr` updates.
    - Read: `o_frame_done` pulses only.
    - addr ≥ `p_num_regs`: no register update, `o_error` and `o_frame_done` pulse.
    - Go to DONE.
  - DONE: extra SCLK edges are ignored and MISO holds 0. CE rising goes to IDLE.
- CE rising in CMD or DATA: frame aborted, no write, `o_error` pulses, go to IDLE.
- CE rising and the 16th leading edge in the same clk cycle: the 16th edge wins. Frame completes normally, then go to IDLE.
- MISO is 0 in IDLE, CMD (before data phase) and DONE. The block has no tristate.
- Reset mid-frame: all state returns to reset values; the frame is discarded without an error pulse.

## Timing
- Reset values:
  - `op_regs` = all 0x00; `op_wr_addr` = 0.
  - `o_miso`, `o_wr_strobe`, `o_frame_done`, `o_error` = 0.
  - State IDLE, counter 0.
- SCLK high and low phases must each be ≥ 4 clk cycles (synchronizer + edge detect).
- Input-to-action latency: 3 clk cycles from a raw SCLK edge to the internal sample or MISO update.
- Write commit: `op_regs` updates in the same cycle `o_wr_strobe` is high, 3 cycles after the raw 16th leading edge.
- Outputs are registered. Pulses last exactly one clk cycle.

## Configuration
- `SPI_RESP_TIMEOUT_EN` defined:
  - A counter clears on every SCLK edge and counts while in CMD or DATA.
  - Reaching `p_timeout` aborts the frame: `o_error` pulses, no write, go to DONE. A new frame requires CE high then low.
- `SPI_RESP_TIMEOUT_EN` undefined: no counter exists; a stalled frame waits indefinitely for SCLK or CE.

## Test plan
- Write: reset, then frame 0x05A7 (write, addr 5, data 0xA7) → reg5 = 0xA7, one `o_wr_strobe`, `op_wr_addr` = 5, one `o_frame_done`, other registers 0x00.
- Readback: after the write above, frame 0x8500 → MISO bits 7:0 = 0xA7, `o_frame_done` pulses, no `o_wr_strobe`, reg5 unchanged.
- Out of range: with `p_num_regs`=16, write frame 0x1455 (addr 20) → `o_error` pulse, no register change. Read 0x9400 → MISO returns 0x00.
- Abort: CE rises after 10 SCLK cycles of a write frame → `o_error` pulse, no write. The next full frame completes normally.
- Mode and overrun: with `p_cpol`=1, write 0x0233 then read 0x8200 → MISO returns 0x33. Send 20 SCLK cycles in one CE window → only one write and extra bits ignored.
- Timeout (`SPI_RESP_TIMEOUT_EN`, `p_timeout`=64): stall SCLK for 100 clk cycles after 4 bits → `o_error` at cycle 64 of the stall and no write. CE high then low plus a full frame recovers.

Source files
------------

// File: rtl/spi_reg_responder.sv
// SPI mode-0/2 register responder: 16-bit frames (R/nW, 7-bit address, 8-bit data) over a bank
// of 8-bit registers. Optional mid-frame SCLK stall abort when SPI_RESP_TIMEOUT_EN is defined.
module spi_reg_responder #(
  parameter int unsigned p_num_regs = 16,
  parameter bit          p_cpol     = 1'b0,
  parameter int unsigned p_timeout  = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_sclk,
  input  logic                    i_mosi,
  input  logic                    i_ce,
  output logic                    o_miso,
  output logic [8*p_num_regs-1:0] op_regs,
  output logic                    o_wr_strobe,
  output logic [6:0]              op_wr_addr,
  output logic                    o_frame_done,
  output logic                    o_error
);

  localparam int unsigned p_aw = (p_num_regs > 1) ? $clog2(p_num_regs) : 1;

  if (p_num_regs < 1 || p_num_regs > 128 || p_timeout < 1) begin : g_param_check
    $error("spi_reg_responder: p_num_regs must be 1..128 and p_timeout nonzero");
  end

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  state_e                         r_state;
  logic                           r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic                           r_mosi_meta, r_mosi_sync;
  logic                           r_ce_meta, r_ce_sync, r_ce_prev;
  logic [3:0]                     r_bit_cnt;
  logic [6:0]                     r_shift;
  logic                           r_rnw;
  logic [6:0]                     r_addr;
  logic [7:0]                     r_tx;
  logic                           r_miso;
  logic [p_num_regs-1:0][7:0]     r_regs;
  logic                           r_wr_strobe;
  logic [6:0]                     r_wr_addr;
  logic                           r_frame_done;
  logic                           r_error;

  logic                           w_sclk_edge, w_lead, w_trail;
  logic                           w_ce_fall, w_ce_rise;
  logic [7:0]                     w_byte;
  logic                           w_cmd_ok, w_addr_ok;
  logic [p_aw-1:0]                w_cmd_idx, w_addr_idx;
  logic                           w_timeout;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sclk_meta <= p_cpol;
      r_sclk_sync <= p_cpol;
      r_sclk_prev <= p_cpol;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_ce_meta   <= 1'b1;
      r_ce_sync   <= 1'b1;
      r_ce_prev   <= 1'b1;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
      r_ce_meta   <= i_ce;
      r_ce_sync   <= r_ce_meta;
      r_ce_prev   <= r_ce_sync;
    end
  end

  // Leading edge moves SCLK away from its idle level; trailing edge returns to it.
  assign w_sclk_edge = r_sclk_sync ^ r_sclk_prev;
  assign w_lead      = w_sclk_edge && (r_sclk_sync != p_cpol);
  assign w_trail     = w_sclk_edge && (r_sclk_sync == p_cpol);
  assign w_ce_fall   = r_ce_prev & ~r_ce_sync;
  assign w_ce_rise   = ~r_ce_prev & r_ce_sync;

  assign w_byte      = {r_shift, r_mosi_sync};
  assign w_cmd_ok    = (32'(w_byte[6:0]) < p_num_regs);
  assign w_addr_ok   = (32'(r_addr) < p_num_regs);
  assign w_cmd_idx   = w_byte[p_aw-1:0];
  assign w_addr_idx  = r_addr[p_aw-1:0];

`ifdef SPI_RESP_TIMEOUT_EN
  localparam int unsigned p_tw = $clog2(p_timeout + 1);
  logic [p_tw-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (!resetn || w_sclk_edge || !(r_state == StCmd || r_state == StData)) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_to_cnt == p_tw'(p_timeout - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 7'd0;
      r_rnw        <= 1'b0;
      r_addr       <= 7'd0;
      r_tx         <= 8'h00;
      r_miso       <= 1'b0;
      r_regs       <= '0;
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= 7'd0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_wr_strobe  <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_bit_cnt <= 4'd0;
          r_miso    <= 1'b0;
          if (w_ce_fall) r_state <= StCmd;
        end
        StCmd: begin
          if (w_ce_rise) begin
            r_error   <= 1'b1;
            r_bit_cnt <= 4'd0;
            r_state   <= StIdle;
          end else if (w_lead) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_rnw   <= w_byte[7];
              r_addr  <= w_byte[6:0];
              r_tx    <= (w_byte[7] && w_cmd_ok) ? r_regs[w_cmd_idx] : 8'h00;
              r_state <= StData;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= StDone;
          end
        end
        StData: begin
          // The 16th leading edge outranks a simultaneous CE rise.
          if (w_lead && r_bit_cnt == 4'd15) begin
            r_frame_done <= 1'b1;
            r_miso       <= 1'b0;
            r_bit_cnt    <= 4'd0;
            if (!w_addr_ok) begin
              r_error <= 1'b1;
            end else if (!r_rnw) begin
              r_regs[w_addr_idx] <= w_byte;
              r_wr_strobe        <= 1'b1;
              r_wr_addr          <= r_addr;
            end
            r_state <= w_ce_rise ? StIdle : StDone;
          end else if (w_ce_rise) begin
            r_error   <= 1'b1;
            r_miso    <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_state   <= StIdle;
          end else if (w_lead) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (w_trail) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_miso  <= 1'b0;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_miso    <= 1'b0;
          r_bit_cnt <= 4'd0;
          if (w_ce_rise) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_miso       = r_miso;
  assign op_regs      = r_regs;
  assign o_wr_strobe  = r_wr_strobe;
  assign op_wr_addr   = r_wr_addr;
  assign o_frame_done = r_frame_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: a CPOL=0 and a CPOL=1 instance see the same frames; a register
// model and an expectation queue check read data, pulses and the register bank after every frame.
module tb_spi_reg_responder;

`ifdef SPI_RESP_TIMEOUT_EN
  localparam int unsigned TbTimeout = 64;
`else
  localparam int unsigned TbTimeout = 1024;
`endif
  localparam int Half = 6;

  typedef struct {
    logic       chk_rx;
    logic [7:0] rx;
    int         strobes;
    int         dones;
    int         errs;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         r_sclk = 1'b0;
  logic         r_mosi = 1'b0;
  logic         r_ce = 1'b1;
  logic         w_sclk_n;
  logic         w_miso0, w_miso1;
  logic [127:0] w_regs0, w_regs1;
  logic         w_strobe0, w_strobe1;
  logic [6:0]   w_wr_addr0, w_wr_addr1;
  logic         w_done0, w_done1;
  logic         w_err0, w_err1;

  int           n_checks = 0;
  int           n_fail = 0;
  int           s0 = 0, s1 = 0, d0 = 0, d1 = 0, e0 = 0, e1 = 0, n_long = 0;
  logic         p_s0 = 1'b0, p_d0 = 1'b0, p_e0 = 1'b0;
  logic [127:0] m_regs = '0;
  logic [6:0]   m_wr_addr = 7'd0;
  exp_t         q[$];

  assign w_sclk_n = ~r_sclk;

  always #5 clk = ~clk;

  spi_reg_responder #(.p_num_regs(16), .p_cpol(1'b0), .p_timeout(TbTimeout)) u_dut0 (
    .clk         (clk),
    .resetn      (resetn),
    .i_sclk      (r_sclk),
    .i_mosi      (r_mosi),
    .i_ce        (r_ce),
    .o_miso      (w_miso0),
    .op_regs     (w_regs0),
    .o_wr_strobe (w_strobe0),
    .op_wr_addr  (w_wr_addr0),
    .o_frame_done(w_done0),
    .o_error     (w_err0)
  );

  spi_reg_responder #(.p_num_regs(16), .p_cpol(1'b1), .p_timeout(TbTimeout)) u_dut1 (
    .clk         (clk),
    .resetn      (resetn),
    .i_sclk      (w_sclk_n),
    .i_mosi      (r_mosi),
    .i_ce        (r_ce),
    .o_miso      (w_miso1),
    .op_regs     (w_regs1),
    .o_wr_strobe (w_strobe1),
    .op_wr_addr  (w_wr_addr1),
    .o_frame_done(w_done1),
    .o_error     (w_err1)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w_strobe0) s0 <= s0 + 1;
    if (w_strobe1) s1 <= s1 + 1;
    if (w_done0)   d0 <= d0 + 1;
    if (w_done1)   d1 <= d1 + 1;
    if (w_err0)    e0 <= e0 + 1;
    if (w_err1)    e1 <= e1 + 1;
    if ((w_strobe0 && p_s0) || (w_done0 && p_d0) || (w_err0 && p_e0)) n_long <= n_long + 1;
    p_s0 <= w_strobe0;
    p_d0 <= w_done0;
    p_e0 <= w_err0;
    // Register must hold the written byte in the very cycle the strobe is seen.
    if (w_strobe0) check_eq("commit_same_cycle", 128'(w_regs0[w_wr_addr0[3:0]*8 +: 8]),
                            128'(m_regs[w_wr_addr0[3:0]*8 +: 8]));
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [15:0] word, input int nbits, input int stall,
                          output logic [7:0] rx0, output logic [7:0] rx1);
    rx0  = 8'h00;
    rx1  = 8'h00;
    r_ce = 1'b0;
    wait_clks(Half);
    for (int i = 0; i < nbits; i++) begin
      r_mosi = (i < 16) ? word[15-i] : 1'b0;
      wait_clks(Half);
      if (i >= 8 && i < 16) begin
        rx0[15-i] = w_miso0;
        rx1[15-i] = w_miso1;
      end
      r_sclk = 1'b1;
      wait_clks(Half);
      r_sclk = 1'b0;
    end
    wait_clks(Half + stall);
    r_ce = 1'b1;
    wait_clks(8);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word, input int nbits,
                           input int stall);
    exp_t       e;
    int         addr;
    logic       valid, complete;
    int         bs0, bs1, bd0, bd1, be0, be1;
    logic [7:0] rx0, rx1;
    addr      = int'(word[14:8]);
    valid     = addr < 16;
    complete  = nbits >= 16;
    e.dones   = complete ? 1 : 0;
    e.strobes = (complete && !word[15] && valid) ? 1 : 0;
    e.errs    = (!complete || !valid) ? 1 : 0;
    e.chk_rx  = complete && word[15];
    e.rx      = valid ? m_regs[addr*8 +: 8] : 8'h00;
    if (e.strobes == 1) begin
      m_regs[addr*8 +: 8] = word[7:0];
      m_wr_addr           = word[14:8];
    end
    q.push_back(e);
    bs0 = s0; bs1 = s1; bd0 = d0; bd1 = d1; be0 = e0; be1 = e1;
    spi_xfer(word, nbits, stall, rx0, rx1);
    e = q.pop_front();
    if (e.chk_rx) begin
      check_eq({tag, ".rx0"}, 128'(rx0), 128'(e.rx));
      check_eq({tag, ".rx1"}, 128'(rx1), 128'(e.rx));
    end
    check_eq({tag, ".strobe0"}, 128'(s0 - bs0), 128'(e.strobes));
    check_eq({tag, ".strobe1"}, 128'(s1 - bs1), 128'(e.strobes));
    check_eq({tag, ".done0"}, 128'(d0 - bd0), 128'(e.dones));
    check_eq({tag, ".done1"}, 128'(d1 - bd1), 128'(e.dones));
    check_eq({tag, ".err0"}, 128'(e0 - be0), 128'(e.errs));
    check_eq({tag, ".err1"}, 128'(e1 - be1), 128'(e.errs));
    check_eq({tag, ".regs0"}, w_regs0, m_regs);
    check_eq({tag, ".regs1"}, w_regs1, m_regs);
    check_eq({tag, ".wr_addr0"}, 128'(w_wr_addr0), 128'(m_wr_addr));
    check_eq({tag, ".wr_addr1"}, 128'(w_wr_addr1), 128'(m_wr_addr));
    check_eq({tag, ".miso_idle0"}, 128'(w_miso0), 128'(0));
  endtask

  initial begin
    logic [6:0] a;
    logic [7:0] dt;
    int         be;
    wait_clks(4);
    resetn = 1'b1;
    wait_clks(4);

    check_eq("reset.regs0", w_regs0, 128'(0));
    check_eq("reset.regs1", w_regs1, 128'(0));
    check_eq("reset.miso0", 128'(w_miso0), 128'(0));
    check_eq("reset.wr_addr0", 128'(w_wr_addr0), 128'(0));
    check_eq("reset.pulses", 128'(s0 + d0 + e0 + s1 + d1 + e1), 128'(0));

    run_frame("write5", 16'h05A7, 16, 0);
    run_frame("read5", 16'h8500, 16, 0);
    run_frame("write_oor", 16'h1455, 16, 0);
    run_frame("read_oor", 16'h9400, 16, 0);
    run_frame("abort", 16'h0A3C, 10, 0);
    run_frame("after_abort", 16'h0A3C, 16, 0);
    run_frame("write2", 16'h0233, 16, 0);
    run_frame("read2", 16'h8200, 16, 0);
    run_frame("overrun", 16'h0366, 20, 0);
    run_frame("read3", 16'h8300, 16, 0);
    run_frame("readA", 16'h8A00, 16, 0);

    for (int i = 0; i < 6; i++) begin
      a  = 7'($urandom_range(0, 19));
      dt = 8'($urandom_range(0, 255));
      run_frame("rnd_wr", {1'b0, a, dt}, 16, 0);
      run_frame("rnd_rd", {1'b1, a, 8'h00}, 16, 0);
    end

`ifdef SPI_RESP_TIMEOUT_EN
    run_frame("timeout", 16'h0411, 4, 100);
    run_frame("after_timeout", 16'h0422, 16, 0);
    run_frame("read_after_to", 16'h8400, 16, 0);
`endif

    // Reset in the middle of a frame discards it silently.
    be     = e0;
    r_ce   = 1'b0;
    r_mosi = 1'b0;
    wait_clks(Half);
    for (int i = 0; i < 6; i++) begin
      r_sclk = 1'b1;
      wait_clks(Half);
      r_sclk = 1'b0;
      wait_clks(Half);
    end
    resetn = 1'b0;
    wait_clks(2);
    r_ce = 1'b1;
    wait_clks(4);
    resetn = 1'b1;
    wait_clks(8);
    m_regs    = '0;
    m_wr_addr = 7'd0;
    check_eq("midreset.err", 128'(e0 - be), 128'(0));
    check_eq("midreset.regs0", w_regs0, m_regs);
    check_eq("midreset.wr_addr0", 128'(w_wr_addr0), 128'(0));
    run_frame("post_reset_wr", 16'h01C3, 16, 0);
    run_frame("post_reset_rd", 16'h8100, 16, 0);

    check_eq("pulse_width", 128'(n_long), 128'(0));
    check_eq("queue_empty", 128'(q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
